branch_predictor: RTL and testbench

- Dynamic branch predictor for the five-stage MIPS pipeline.
- Replaces static predict-not-taken plus MEM-stage flush.
- Direct-mapped branch target buffer (BTB), tagged, with per-entry saturating counters. Looked up combinationally with the IF-stage PC.
- Trained from the resolving stage with actual outcome and target. Keeps hit and mispredict statistics for the debug monitor.

---
 rtl/branch_predictor_pkg.sv | 42 ++++
 rtl/branch_predictor_if.sv | 30 +++
 rtl/branch_predictor_sat_counter.sv | 31 +++
 rtl/branch_predictor.sv | 107 ++++++++++
 tb/tb_branch_predictor.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared constants, width helpers and counter encodings for the BTB predictor.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package branch_predictor_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int ENTRIES_DEF  = 16;
    localparam int CTR_BITS_DEF = 2;
    localparam int CNT_W_DEF    = 32;

    // Counter encodings at the default counter width.
    localparam int CTR_MAX    = (1 << CTR_BITS_DEF) - 1;
    localparam int CTR_WEAK_T = 1 << (CTR_BITS_DEF - 1);

    function automatic int f_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int f_idx_w(input int entries);
        return f_clog2(entries);
    endfunction

    // pc[1:0] is never part of index or tag.
    function automatic int f_tag_w(input int xlen, input int entries);
        return xlen - f_clog2(entries) - 2;
    endfunction

    function automatic int f_ctr_max(input int bits);
        return (1 << bits) - 1;
    endfunction

    // Lowest count whose MSB is set: freshly allocated entries start weakly taken.
    function automatic int f_ctr_weak_t(input int bits);
        return 1 << (bits - 1);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Lookup/update bundle between the pipeline (master) and the predictor (slave).
// Latency: lookup and mispredict are combinational; updates land on the next clk edge.
// Backpressure: none; the predictor accepts an update every cycle.
interface branch_predictor_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc_if;            // IF-stage PC to look up
    logic            pred_taken;       // predicted taken
    logic [XLEN-1:0] pred_target;      // predicted target, 0 when not taken
    logic            upd_valid;        // resolving branch/jump this cycle
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            upd_pred_taken;   // prediction carried down the pipeline
    logic [XLEN-1:0] upd_pred_target;
    logic            inv;              // invalidate every entry
    logic            mispredict;       // carried prediction was wrong

    modport master (
        output pc_if, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target, inv,
        input  pred_taken, pred_target, mispredict
    );

    modport slave (
        input  pc_if, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target, inv,
        output pred_taken, pred_target, mispredict
    );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down counter with synchronous load; sticks at 0 and all-ones.
// Latency: 1 cycle (registered). Priority rst > load > inc/dec; inc and dec together hold.
// Backpressure: none.
// Ports: clk, rst, i_inc, i_dec, i_load, i_load_val -> o_q.
module branch_predictor_sat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_dec,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_inc && !i_dec && (r_q != '1)) begin
            r_q <= r_q + W'(1);
        end else if (i_dec && !i_inc && (r_q != '0)) begin
            r_q <= r_q - W'(1);
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped tagged BTB with per-entry saturating counters plus hit/mispredict stats.
// Latency: lookup and mispredict combinational; training and stats update on next clk edge.
// Backpressure: none; one update per cycle, dropped if rst or inv is asserted with it.
// Ports: clk, rst (sync, active-high); bp (slave side of branch_predictor_if);
//        stat_lookups / stat_mispred saturating statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int ENTRIES  = ENTRIES_DEF,
    parameter int CTR_BITS = CTR_BITS_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_predictor_if.slave    bp,
    output logic [CNT_W-1:0]     stat_lookups,
    output logic [CNT_W-1:0]     stat_mispred
);
    localparam int IDX_W = f_idx_w(ENTRIES);
    localparam int TAG_W = f_tag_w(XLEN, ENTRIES);
    localparam logic [CTR_BITS-1:0] C_WEAK_T = CTR_BITS'(f_ctr_weak_t(CTR_BITS));

    // The entry's counter lives in its own sat_counter instance (w_ctr).
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
    } entry_t;

    entry_t              r_tab [ENTRIES];
    logic [CTR_BITS-1:0] w_ctr [ENTRIES];

    logic [IDX_W-1:0] w_lk_idx, w_up_idx;
    logic [TAG_W-1:0] w_lk_tag, w_up_tag;
    logic             w_lk_hit, w_up_hit, w_upd;
    logic             w_unused;

    assign w_lk_idx = bp.pc_if[IDX_W+1:2];
    assign w_lk_tag = bp.pc_if[XLEN-1:IDX_W+2];
    assign w_up_idx = bp.upd_pc[IDX_W+1:2];
    assign w_up_tag = bp.upd_pc[XLEN-1:IDX_W+2];
    assign w_unused = ^{bp.pc_if[1:0], bp.upd_pc[1:0]};

    // Lookup reads current register contents, so a same-cycle update is not visible yet.
    assign w_lk_hit       = r_tab[w_lk_idx].valid && (r_tab[w_lk_idx].tag == w_lk_tag);
    assign bp.pred_taken  = w_lk_hit && w_ctr[w_lk_idx][CTR_BITS-1];
    assign bp.pred_target = bp.pred_taken ? r_tab[w_lk_idx].target : '0;

    assign bp.mispredict = bp.upd_valid &&
                           ((bp.upd_pred_taken != bp.upd_taken) ||
                            (bp.upd_taken && (bp.upd_pred_target != bp.upd_target)));

    // rst is handled inside each register's own priority; inv drops the update here.
    assign w_upd    = bp.upd_valid && !bp.inv;
    assign w_up_hit = r_tab[w_up_idx].valid && (r_tab[w_up_idx].tag == w_up_tag);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < ENTRIES; e++) r_tab[e] <= '0;
        end else if (bp.inv) begin
            for (int e = 0; e < ENTRIES; e++) r_tab[e].valid <= 1'b0;
        end else if (w_upd && bp.upd_taken) begin
            // Taken: a hit refreshes the target, a miss evicts whatever is there.
            r_tab[w_up_idx].target <= bp.upd_target;
            if (!w_up_hit) begin
                r_tab[w_up_idx].valid <= 1'b1;
                r_tab[w_up_idx].tag   <= w_up_tag;
            end
        end
    end

    for (genvar e = 0; e < ENTRIES; e++) begin : g_ctr
        logic w_sel;
        assign w_sel = w_upd && (w_up_idx == IDX_W'(e));

        branch_predictor_sat_counter #(.W(CTR_BITS)) u_ctr (
            .clk        (clk),
            .rst        (rst),
            .i_inc      (w_sel && w_up_hit && bp.upd_taken),
            .i_dec      (w_sel && w_up_hit && !bp.upd_taken),
            .i_load     (w_sel && !w_up_hit && bp.upd_taken),
            .i_load_val (C_WEAK_T),
            .o_q        (w_ctr[e])
        );
    end

    branch_predictor_sat_counter #(.W(CNT_W)) u_stat_lookups (
        .clk        (clk),
        .rst        (rst),
        .i_inc      (w_upd),
        .i_dec      (1'b0),
        .i_load     (1'b0),
        .i_load_val ('0),
        .o_q        (stat_lookups)
    );

    branch_predictor_sat_counter #(.W(CNT_W)) u_stat_mispred (
        .clk        (clk),
        .rst        (rst),
        .i_inc      (w_upd && bp.mispredict),
        .i_dec      (1'b0),
        .i_load     (1'b0),
        .i_load_val ('0),
        .o_q        (stat_mispred)
    );
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor (ENTRIES=16, CTR_BITS=2, CNT_W=4).
// Each vector is driven just after a rising edge; its expectation is queued and a
// monitor on the falling edge pops and compares all observable outputs.
module tb_branch_predictor;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    typedef struct {
        string       nm;
        logic        pt;
        logic [31:0] tgt;
        logic        mis;
        int          lk;
        int          mp;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             chk_vld = 1'b0;
    logic [CNT_W-1:0] stat_lookups, stat_mispred;
    exp_t             q[$];
    exp_t             cur;
    int               n_pass = 0;
    int               n_total = 0;

    branch_predictor_if #(.XLEN(XLEN)) bus ();

    branch_predictor #(
        .XLEN(XLEN), .ENTRIES(16), .CTR_BITS(2), .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bp           (bus),
        .stat_lookups (stat_lookups),
        .stat_mispred (stat_mispred)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, exp);
    endtask

    // Monitor: compare whatever the DUT presents against the oldest expectation.
    always @(negedge clk) begin
        if (chk_vld) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL scoreboard: check requested with empty queue got 0 expected 1");
            end else begin
                cur = q.pop_front();
                chk(cur.nm, "pred_taken",   {31'b0, bus.pred_taken}, {31'b0, cur.pt});
                chk(cur.nm, "pred_target",  bus.pred_target, cur.tgt);
                chk(cur.nm, "mispredict",   {31'b0, bus.mispredict}, {31'b0, cur.mis});
                chk(cur.nm, "stat_lookups", {28'b0, stat_lookups}, cur.lk);
                chk(cur.nm, "stat_mispred", {28'b0, stat_mispred}, cur.mp);
            end
        end
    end

    task automatic vec(input string nm, input logic [31:0] pc, input logic uv,
                       input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                       input logic upt, input logic [31:0] uptgt,
                       input logic inv_i, input logic rst_i,
                       input logic e_pt, input logic [31:0] e_tgt, input logic e_mis,
                       input int e_lk, input int e_mp);
        exp_t e;
        bus.pc_if           = pc;
        bus.upd_valid       = uv;
        bus.upd_pc          = upc;
        bus.upd_taken       = ut;
        bus.upd_target      = utgt;
        bus.upd_pred_taken  = upt;
        bus.upd_pred_target = uptgt;
        bus.inv             = inv_i;
        rst                 = rst_i;
        e.nm = nm; e.pt = e_pt; e.tgt = e_tgt; e.mis = e_mis; e.lk = e_lk; e.mp = e_mp;
        q.push_back(e);
        chk_vld = 1'b1;
        @(posedge clk);
        #1;
        chk_vld = 1'b0;
    endtask

    task automatic idle(input string nm, input logic [31:0] pc, input logic e_pt,
                        input logic [31:0] e_tgt, input int e_lk, input int e_mp);
        vec(nm, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0,
            e_pt, e_tgt, 1'b0, e_lk, e_mp);
    endtask

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pc_if = '0; bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0;
        bus.upd_target = '0; bus.upd_pred_taken = 1'b0; bus.upd_pred_target = '0;
        bus.inv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        //   name           pc      uv upc     ut utgt    upt uptgt   inv rst  pt tgt     mis lk mp
        vec("reset",       32'h40, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 0,  0, 32'h0,  0, 0, 0);
        vec("alloc",       32'h40, 1, 32'h40, 1, 32'h10, 0, 32'h0,  0, 0,  0, 32'h0,  1, 0, 0);
        idle("hit",        32'h40, 1, 32'h10, 1, 1);
        vec("nt1_rbw",     32'h40, 1, 32'h40, 0, 32'h0,  1, 32'h10, 0, 0,  1, 32'h10, 1, 1, 1);
        vec("nt2",         32'h40, 1, 32'h40, 0, 32'h0,  0, 32'h0,  0, 0,  0, 32'h0,  0, 2, 2);
        vec("t1",          32'h40, 1, 32'h40, 1, 32'h10, 0, 32'h0,  0, 0,  0, 32'h0,  1, 3, 2);
        vec("t2",          32'h40, 1, 32'h40, 1, 32'h10, 0, 32'h0,  0, 0,  0, 32'h0,  1, 4, 3);
        vec("t3",          32'h40, 1, 32'h40, 1, 32'h10, 1, 32'h10, 0, 0,  1, 32'h10, 0, 5, 4);
        vec("t4_tgtmis",   32'h40, 1, 32'h40, 1, 32'h20, 1, 32'h10, 0, 0,  1, 32'h10, 1, 6, 4);
        vec("sat_dec",     32'h40, 1, 32'h40, 0, 32'h0,  1, 32'h20, 0, 0,  1, 32'h20, 1, 7, 5);
        vec("ctr2_dec",    32'h40, 1, 32'h40, 0, 32'h0,  1, 32'h20, 0, 0,  1, 32'h20, 1, 8, 6);
        idle("ctr1",       32'h40, 0, 32'h0,  9, 7);
        vec("alias_alloc", 32'h80, 1, 32'h80, 1, 32'h44, 0, 32'h0,  0, 0,  0, 32'h0,  1, 9, 7);
        idle("alias_old",  32'h40, 0, 32'h0,  10, 8);
        idle("alias_new",  32'h80, 1, 32'h44, 10, 8);
        vec("inv_upd",     32'h80, 1, 32'h80, 0, 32'h0,  1, 32'h44, 1, 0,  1, 32'h44, 1, 10, 8);
        idle("after_inv",  32'h80, 0, 32'h0,  10, 8);
        vec("realloc",     32'h80, 1, 32'h80, 1, 32'h48, 0, 32'h0,  0, 0,  0, 32'h0,  1, 10, 8);
        idle("realloc_hit",32'h80, 1, 32'h48, 11, 9);
        for (int i = 0; i < 20; i++) begin
            vec("stat_sat", 32'h80, 1, 32'h104, 0, 32'h0, 1, 32'h0, 0, 0,
                1, 32'h48, 1, sat15(11 + i), sat15(9 + i));
        end
        idle("sat_final",  32'h80, 1, 32'h48, 15, 15);
        vec("rst_mid",     32'h80, 1, 32'h104, 0, 32'h0, 1, 32'h0,  0, 1,  1, 32'h48, 1, 15, 15);
        idle("post_rst80", 32'h80, 0, 32'h0,  0, 0);
        idle("post_rst40", 32'h40, 0, 32'h0,  0, 0);
        @(posedge clk);
        #1;
        n_total++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
